osc_scan_ctrl: RTL and testbench

Measurement sequencer for the ring-oscillator counter bank. On START it clears all counters, gates the oscillators on for a programmed window of CLK cycles, then freezes them and walks ADDRESS across the bank. Each selected COUNT is captured after a settle delay and streamed out on a valid/ready interface. It sits between the bank and the host/readout logic and is the only driver of the bank's RESET, enable and ADDRESS inputs.

---
 rtl/osc_scan_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_osc_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_scan_ctrl.sv
// rtl/osc_scan_ctrl.sv - ring-oscillator bank measurement sequencer and count readout streamer
// Optional capture-stability filter enabled by defining OSC_SCAN_STABLE_EN.
module osc_scan_ctrl #(
    parameter int COUNTER_LENGTH = 128,
    parameter int BANK_SIZE      = 16,
    parameter int ADDRESS_SIZE   = 4,
    parameter int CLEAR_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int WINDOW_WIDTH   = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic                      ABORT,
    input  logic [WINDOW_WIDTH-1:0]   WINDOW,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      OSC_RESET,
    output logic                      OSC_EN,
    output logic [ADDRESS_SIZE-1:0]   ADDRESS,
    input  logic [COUNTER_LENGTH-1:0] COUNT,
    output logic [COUNTER_LENGTH-1:0] DATA_OUT,
    output logic [ADDRESS_SIZE-1:0]   DATA_ADDR,
    output logic                      DATA_ERR,
    output logic                      DATA_VALID,
    input  logic                      DATA_READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_OUTPUT,
        S_FINISH
    } state_t;

    localparam logic [WINDOW_WIDTH-1:0] ONE_W       = WINDOW_WIDTH'(1);
    localparam logic [WINDOW_WIDTH-1:0] CLEAR_LAST  = WINDOW_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [WINDOW_WIDTH-1:0] SETTLE_LAST = WINDOW_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR   = ADDRESS_SIZE'(BANK_SIZE - 1);

    state_t                    state_q, state_d;
    logic [WINDOW_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WINDOW_WIDTH-1:0]   win_len_q, win_len_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      osc_reset_q, osc_reset_d;
    logic                      osc_en_q, osc_en_d;
    logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
    logic [COUNTER_LENGTH-1:0] data_q, data_d;
    logic [ADDRESS_SIZE-1:0]   daddr_q, daddr_d;
    logic                      valid_q, valid_d;
`ifdef OSC_SCAN_STABLE_EN
    localparam logic [WINDOW_WIDTH-1:0] SAMPLE_LAST = WINDOW_WIDTH'(7);
    logic [COUNTER_LENGTH-1:0] smp_q, smp_d;
    logic                      derr_q, derr_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + ONE_W;
        win_len_d   = win_len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        osc_reset_d = osc_reset_q;
        osc_en_d    = osc_en_q;
        addr_d      = addr_q;
        data_d      = data_q;
        daddr_d     = daddr_q;
        valid_d     = valid_q;
`ifdef OSC_SCAN_STABLE_EN
        smp_d       = smp_q;
        derr_d      = derr_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d       = '0;
                busy_d      = 1'b0;
                osc_reset_d = 1'b1;
                osc_en_d    = 1'b0;
                addr_d      = '0;
                valid_d     = 1'b0;
                if (START) begin
                    win_len_d = (WINDOW == '0) ? ONE_W : WINDOW;
                    busy_d    = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    cnt_d       = '0;
                    osc_reset_d = 1'b0;
                    osc_en_d    = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == win_len_q - ONE_W) begin
                    cnt_d    = '0;
                    osc_en_d = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
`ifdef OSC_SCAN_STABLE_EN
                // Accept a count only once two consecutive samples agree; give up after 8.
                smp_d = COUNT;
                if (cnt_q != '0 && COUNT == smp_q) begin
                    data_d  = COUNT;
                    daddr_d = addr_q;
                    derr_d  = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_OUTPUT;
                end else if (cnt_q == SAMPLE_LAST) begin
                    data_d  = COUNT;
                    daddr_d = addr_q;
                    derr_d  = 1'b1;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_OUTPUT;
                end
`else
                data_d  = COUNT;
                daddr_d = addr_q;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = S_OUTPUT;
`endif
            end
            S_OUTPUT: begin
                cnt_d = '0;
                if (valid_q && DATA_READY) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_FINISH: begin
                cnt_d       = '0;
                busy_d      = 1'b0;
                osc_reset_d = 1'b1;
                addr_d      = '0;
                state_d     = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a handshake completing this cycle.
        if (ABORT && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            osc_reset_d = 1'b1;
            osc_en_d    = 1'b0;
            addr_d      = '0;
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_len_q   <= ONE_W;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            osc_reset_q <= 1'b1;
            osc_en_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            daddr_q     <= '0;
            valid_q     <= 1'b0;
`ifdef OSC_SCAN_STABLE_EN
            smp_q       <= '0;
            derr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_len_q   <= win_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            osc_reset_q <= osc_reset_d;
            osc_en_q    <= osc_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            daddr_q     <= daddr_d;
            valid_q     <= valid_d;
`ifdef OSC_SCAN_STABLE_EN
            smp_q       <= smp_d;
            derr_q      <= derr_d;
`endif
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign OSC_RESET  = osc_reset_q;
    assign OSC_EN     = osc_en_q;
    assign ADDRESS    = addr_q;
    assign DATA_OUT   = data_q;
    assign DATA_ADDR  = daddr_q;
    assign DATA_VALID = valid_q;
`ifdef OSC_SCAN_STABLE_EN
    assign DATA_ERR   = derr_q;
`else
    assign DATA_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_osc_scan_ctrl.sv
// tb/tb_osc_scan_ctrl.sv - randomized scoreboard bench for osc_scan_ctrl
module tb_osc_scan_ctrl;
    localparam int CL = 128;
    localparam int BS = 16;
    localparam int AS = 4;
    localparam int CC = 4;
    localparam int SC = 3;
    localparam int WW = 32;
`ifdef OSC_SCAN_STABLE_EN
    localparam int CAPW = 2;
`else
    localparam int CAPW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, abort_i, ready;
    logic [WW-1:0] window;
    logic          busy, done, osc_reset, osc_en, derr, valid;
    logic [AS-1:0] addr, daddr;
    logic [CL-1:0] count, dout;

    logic [CL-1:0] bank [BS];
    logic          jitter = 1'b0;
    logic [CL-1:0] jit_cnt = '0;
    int            rmode = 0;

    always #5 clk = ~clk;

    osc_scan_ctrl #(.COUNTER_LENGTH(CL), .BANK_SIZE(BS), .ADDRESS_SIZE(AS),
                    .CLEAR_CYCLES(CC), .SETTLE_CYCLES(SC), .WINDOW_WIDTH(WW)) dut (
        .CLK(clk), .RESET(rst_n), .START(start), .ABORT(abort_i), .WINDOW(window),
        .BUSY(busy), .DONE(done), .OSC_RESET(osc_reset), .OSC_EN(osc_en),
        .ADDRESS(addr), .COUNT(count), .DATA_OUT(dout), .DATA_ADDR(daddr),
        .DATA_ERR(derr), .DATA_VALID(valid), .DATA_READY(ready)
    );

    // Bank model: a held count per oscillator; address 3 can be made to drift.
    assign count = (jitter && addr == AS'(3)) ? bank[3] + jit_cnt : bank[addr];
    always @(posedge clk) jit_cnt <= jit_cnt + 1;

    typedef struct packed {
        logic [AS-1:0] a;
        logic [CL-1:0] d;
        logic          e;
        logic          chk_d;
    } beat_t;

    beat_t   exp_q[$];
    int      n_cmp = 0, n_err = 0;
    int      neg_cnt = 0, start_mark = 0, en_cnt = 0, done_cnt = 0, exp_lat = 0;
    bit      first_pending = 0;
    logic    stall_q = 1'b0;
    logic [CL-1:0] stall_d;
    logic [AS-1:0] stall_a;

    task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       ready = ($urandom_range(0, 2) == 0);
            2:       ready = $urandom_range(0, 1) == 1;
            3:       ready = !(valid && daddr == AS'(5));
            default: ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (stall_q && valid) begin
                check("stall_data", dout, stall_d);
                check("stall_addr", CL'(daddr), CL'(stall_a));
            end
            if (valid && first_pending) begin
                check("first_latency", CL'(neg_cnt - start_mark), CL'(exp_lat));
                first_pending = 0;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got addr %0d expected none", daddr);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_addr", CL'(daddr), CL'(b.a));
                    check("beat_err", CL'(derr), CL'(b.e));
                    if (b.chk_d) check("beat_data", dout, b.d);
                end
            end
            stall_q = valid && !ready;
            stall_d = dout;
            stall_a = daddr;
            if (done) done_cnt++;
            if (osc_en) en_cnt++;
        end else begin
            stall_q = 1'b0;
        end
        neg_cnt++;
    end

    task automatic push_beats();
        for (int a = 0; a < BS; a++) begin
            beat_t b;
            b.a = AS'(a);
            b.d = bank[a];
            b.e = (jitter && a == 3);
            b.chk_d = !(jitter && a == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input logic [WW-1:0] w, input bit with_abort);
        @(posedge clk);
        #1 window = w; start = 1'b1; abort_i = with_abort;
        @(posedge clk);
        start_mark = neg_cnt;
        en_cnt = 0;
        #1 start = 1'b0; abort_i = 1'b0;
        exp_lat = CC + ((w == 0) ? 1 : int'(w)) + SC + CAPW;
        first_pending = 1;
    endtask

    task automatic wait_en(output bit got);
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (osc_en) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_osc_en: got timeout expected OSC_EN");
        end
    endtask

    task automatic full_run(input logic [WW-1:0] w, input bit restart, input bit with_abort);
        int d0;
        bit got;
        d0 = done_cnt;
        push_beats();
        do_start(w, with_abort);
        if (restart) begin
            wait_en(got);
            start = 1'b1;
            window = 32'd5;
            @(posedge clk);
            @(posedge clk);
            #1 start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(posedge clk);
            #2;
            if (done) got = 1;
        end
        check("done_seen", CL'(got), CL'(1));
        repeat (3) @(posedge clk);
        #2;
        check("done_count", CL'(done_cnt - d0), CL'(1));
        check("en_cycles", CL'(en_cnt), CL'((w == 0) ? 1 : int'(w)));
        check("queue_empty", CL'(exp_q.size()), CL'(0));
        check("busy_after", CL'(busy), CL'(0));
        check("osc_reset_after", CL'(osc_reset), CL'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_osc_reset"}, CL'(osc_reset), CL'(1));
        check({tag, "_osc_en"}, CL'(osc_en), CL'(0));
        check({tag, "_address"}, CL'(addr), CL'(0));
        check({tag, "_data_out"}, dout, '0);
        check({tag, "_data_addr"}, CL'(daddr), CL'(0));
        check({tag, "_data_err"}, CL'(derr), CL'(0));
        check({tag, "_valid"}, CL'(valid), CL'(0));
        check({tag, "_busy"}, CL'(busy), CL'(0));
        check({tag, "_done"}, CL'(done), CL'(0));
    endtask

    initial begin
        bit got;
        int d0;
        rst_n = 1'b0; start = 1'b0; abort_i = 1'b0; window = '0; ready = 1'b1;
        for (int a = 0; a < BS; a++) bank[a] = CL'(100 + a);
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;

        full_run(32'd10, 0, 0);

        for (int a = 0; a < BS; a++) bank[a] = {$urandom, $urandom, $urandom, $urandom};
        rmode = 1;
        full_run(WW'($urandom_range(1, 40)), 0, 0);

        rmode = 0;
        full_run(32'd0, 1, 1);

        // Abort while beat 5 is presented and stalled.
        rmode = 3;
        d0 = done_cnt;
        for (int a = 0; a < 5; a++) begin
            beat_t b;
            b.a = AS'(a); b.d = bank[a]; b.e = 1'b0; b.chk_d = 1'b1;
            exp_q.push_back(b);
        end
        do_start(32'd10, 0);
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (valid && daddr == AS'(5)) got = 1;
        end
        check("beat5_seen", CL'(got), CL'(1));
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        check("abort_valid", CL'(valid), CL'(0));
        check("abort_osc_reset", CL'(osc_reset), CL'(1));
        check("abort_busy", CL'(busy), CL'(0));
        repeat (20) @(posedge clk);
        #2;
        check("abort_no_done", CL'(done_cnt - d0), CL'(0));
        check("abort_queue", CL'(exp_q.size()), CL'(0));
        rmode = 0;
        full_run(32'd3, 0, 0);

        // Reset asserted during the gate window.
        do_start(32'd20, 0);
        wait_en(got);
        repeat (3) @(negedge clk);
        first_pending = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_vals("midrun");
        rst_n = 1'b1;

        rmode = 2;
        for (int a = 0; a < BS; a++) bank[a] = {$urandom, $urandom, $urandom, $urandom};
        full_run(WW'($urandom_range(1, 25)), 0, 0);
        rmode = 0;

`ifdef OSC_SCAN_STABLE_EN
        jitter = 1'b1;
        full_run(32'd7, 0, 0);
        jitter = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
